nand_logic_unit: RTL and testbench
==================================

# nand_logic_unit

Parametrised, multi-cycle logic unit that evaluates a selected two-operand Boolean function on WIDTH-bit vectors using only a single WIDTH-bit NAND stage, sequenced by an FSM over one or more clocks. It generalises the lab's gate-level NAND constructions (OR, AND, XOR built from NANDs) into a clocked, handshaked datapath block. It sits between a valid/ready operand source and a valid/ready result sink in the lab datapath.

## Interface
- WIDTH, 8, operand/result width in bits (>= 1)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and op presented
- in_ready  out  1  unit can accept; high only in IDLE
- op  in  3  function select (see Operation)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- out_valid  out  1  res holds a completed result
- out_ready  in  1  sink accepts result
- res  out  WIDTH  result register
- busy  out  1  high in EXEC or DONE
- res_par  out  1  even parity of res (only with NLU_PARITY_EN)

## Operation
- States: IDLE, EXEC, DONE. Internal registers: ra, rb (latched operands), t, p, q (WIDTH-bit temporaries), rop, step (3 bits).
- IDLE: in_ready=1. On in_valid: latch a, b, op into ra, rb, rop; step=0; go to EXEC.
- EXEC: one NAND evaluation per clock, step increments; last step writes res and goes to DONE.
- Step sequences (N = step count), all NAND = bitwise ~(x & y):
  - 0 NAND, N=1: res=NAND(ra,rb)
  - 1 AND, N=2: t=NAND(ra,rb); res=NAND(t,t)
  - 2 OR, N=3: p=NAND(ra,ra); q=NAND(rb,rb); res=NAND(p,q)
  - 3 NOR, N=4: OR sequence into t, then res=NAND(t,t)
  - 4 XOR, N=4: t=NAND(ra,rb); p=NAND(ra,t); q=NAND(rb,t); res=NAND(p,q)
  - 5 XNOR, N=5: XOR sequence into t, then res=NAND(t,t)
  - 6 NOT A, N=1: res=NAND(ra,ra)
  - 7 BUF A, N=2: t=NAND(ra,ra); res=NAND(t,t)
- Only one NAND evaluation per clock; no function may be computed by a non-NAND operator.
- DONE: out_valid=1, res stable. On out_ready: go to IDLE. in_valid ignored in EXEC and DONE (no queuing).
- Reset (any time, including mid-EXEC or DONE): state=IDLE, in_ready=1, out_valid=0, busy=0, res=0, res_par=0, ra/rb/t/p/q/rop/step=0; partial result discarded.

## Timing
- Accept edge E0 (in_valid & in_ready). Steps execute on edges E1..EN; out_valid rises after EN. Latency = N clocks from accept to out_valid.
- out_valid & out_ready on edge D: out_valid falls, in_ready rises after D; earliest next accept is edge D+1. No same-cycle hand-back.
- Minimum issue interval: N+2 clocks (out_ready held high).
- out_ready in IDLE/EXEC has no effect. res holds last result in IDLE until overwritten by the final step of the next op.
- All outputs registered or decoded from state only; no combinational path from inputs to outputs.

## Configuration
- NLU_PARITY_EN defined: res_par port present, registered together with res (res_par = XOR-reduce of value written to res), reset 0.
- Undefined: res_par port and logic absent; all other behaviour identical.

## Test plan
- Reset, then op=2 (OR), a=8'hA5, b=8'h0F -> out_valid exactly 3 clocks after accept, res=8'hAF; with NLU_PARITY_EN res_par=0.
- op=4 (XOR), a=8'hFF, b=8'h0F -> 4 clocks, res=8'hF0; op=5 same operands -> 5 clocks, res=8'h0F.
- Sweep all 8 ops with a=8'hF0, b=8'hCC -> res 3F, C0, FC, 03, 3C, C3, 0F, F0; latencies 1,2,3,4,4,5,1,2.
- Backpressure: op=0, out_ready low 6 clocks -> res, out_valid stable, in_ready=0, new in_valid (a=8'h00) ignored; out_ready high -> IDLE, next accept one clock later.
- Assert rst_n low at step 2 of XOR -> immediately out_valid=0, res=0, in_ready=1; next op=1, a=8'h0F, b=8'h3C gives res=8'h0C after 2 clocks.

Source files
------------

// File: rtl/nand_logic_unit.sv
// Multi-cycle logic unit: evaluates one of eight Boolean functions through a single NAND stage.
// Optional: define NLU_PARITY_EN to add the registered even-parity output res_par.
module nand_logic_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             busy
`ifdef NLU_PARITY_EN
  ,
  output logic             res_par
`endif
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;
  typedef enum logic [2:0] {SrcRa, SrcRb, SrcT, SrcP, SrcQ} src_e;
  typedef enum logic [1:0] {DstT, DstP, DstQ, DstRes} dst_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ra_q, rb_q, t_q, p_q, q_q, res_q;
  logic [2:0]       rop_q, step_q;
  src_e             src_x, src_y;
  dst_e             dst;
  logic             last;
  logic [WIDTH-1:0] opnd_x, opnd_y, nand_out;

  // Per-step schedule: which registers feed the NAND and where its output lands.
  always_comb begin
    src_x = SrcRa;
    src_y = SrcRb;
    dst   = DstRes;
    last  = 1'b0;
    unique case (rop_q)
      3'd0: last = 1'b1;
      3'd1, 3'd7: begin
        if (rop_q == 3'd7) src_y = SrcRa;
        if (step_q == 3'd0) begin
          dst = DstT;
        end else begin
          src_x = SrcT;
          src_y = SrcT;
          last  = 1'b1;
        end
      end
      3'd2, 3'd3: begin
        case (step_q)
          3'd0: begin src_y = SrcRa; dst = DstP; end
          3'd1: begin src_x = SrcRb; dst = DstQ; end
          3'd2: begin
            src_x = SrcP;
            src_y = SrcQ;
            dst   = (rop_q == 3'd2) ? DstRes : DstT;
            last  = (rop_q == 3'd2);
          end
          default: begin src_x = SrcT; src_y = SrcT; last = 1'b1; end
        endcase
      end
      3'd4, 3'd5: begin
        case (step_q)
          3'd0: dst = DstT;
          3'd1: begin src_y = SrcT; dst = DstP; end
          3'd2: begin src_x = SrcRb; src_y = SrcT; dst = DstQ; end
          3'd3: begin
            src_x = SrcP;
            src_y = SrcQ;
            dst   = (rop_q == 3'd4) ? DstRes : DstT;
            last  = (rop_q == 3'd4);
          end
          default: begin src_x = SrcT; src_y = SrcT; last = 1'b1; end
        endcase
      end
      3'd6: begin src_y = SrcRa; last = 1'b1; end
    endcase
  end

  always_comb begin
    opnd_x = ra_q;
    case (src_x)
      SrcRb:   opnd_x = rb_q;
      SrcT:    opnd_x = t_q;
      SrcP:    opnd_x = p_q;
      SrcQ:    opnd_x = q_q;
      default: opnd_x = ra_q;
    endcase
  end

  always_comb begin
    opnd_y = rb_q;
    case (src_y)
      SrcRa:   opnd_y = ra_q;
      SrcT:    opnd_y = t_q;
      SrcP:    opnd_y = p_q;
      SrcQ:    opnd_y = q_q;
      default: opnd_y = rb_q;
    endcase
  end

  assign nand_out = ~(opnd_x & opnd_y);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StExec;
      StExec:  if (last) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra_q   <= '0;
      rb_q   <= '0;
      t_q    <= '0;
      p_q    <= '0;
      q_q    <= '0;
      res_q  <= '0;
      rop_q  <= '0;
      step_q <= '0;
    end else if (state_q == StIdle) begin
      if (in_valid) begin
        ra_q   <= a;
        rb_q   <= b;
        rop_q  <= op;
        step_q <= '0;
      end
    end else if (state_q == StExec) begin
      step_q <= step_q + 3'd1;
      unique case (dst)
        DstT:   t_q   <= nand_out;
        DstP:   p_q   <= nand_out;
        DstQ:   q_q   <= nand_out;
        DstRes: res_q <= nand_out;
      endcase
    end
  end

`ifdef NLU_PARITY_EN
  logic par_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       par_q <= 1'b0;
    else if (state_q == StExec && dst == DstRes)      par_q <= ^nand_out;
  end
  assign res_par = par_q;
`endif

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign res       = res_q;

endmodule

// File: tb/tb_nand_logic_unit.sv
// Self-checking bench for nand_logic_unit: transaction-level model plus directed vectors.
module tb_nand_logic_unit;
  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       op = 3'd0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] res;
  logic             busy;
`ifdef NLU_PARITY_EN
  logic             res_par;
`endif

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  nand_logic_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .busy      (busy)
`ifdef NLU_PARITY_EN
    ,
    .res_par   (res_par)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the Boolean function and step count of each op, straight from the op table.
  function automatic logic [WIDTH-1:0] model_fn(input logic [2:0] o, input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    case (o)
      3'd0:    return ~(x & y);
      3'd1:    return x & y;
      3'd2:    return x | y;
      3'd3:    return ~(x | y);
      3'd4:    return x ^ y;
      3'd5:    return ~(x ^ y);
      3'd6:    return ~x;
      default: return x;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] o);
    int lat_tab [8] = '{1, 2, 3, 4, 4, 5, 1, 2};
    return lat_tab[o];
  endfunction

  bit               m_idle, m_done;
  int               m_cnt;
  logic [WIDTH-1:0] m_pend, m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle <= 1'b1;
      m_done <= 1'b0;
      m_cnt  <= 0;
      m_pend <= '0;
      m_res  <= '0;
    end else if (m_idle) begin
      if (in_valid) begin
        m_idle <= 1'b0;
        m_cnt  <= model_lat(op);
        m_pend <= model_fn(op, a, b);
      end
    end else if (!m_done) begin
      if (m_cnt == 1) begin
        m_done <= 1'b1;
        m_res  <= m_pend;
      end
      m_cnt <= m_cnt - 1;
    end else if (out_ready) begin
      m_done <= 1'b0;
      m_idle <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_in_ready", in_ready, m_idle);
      chk("cyc_busy", busy, !m_idle);
      chk("cyc_out_valid", out_valid, m_done);
      chk("cyc_res", res, m_res);
`ifdef NLU_PARITY_EN
      chk("cyc_res_par", res_par, ^m_res);
`endif
    end
  end

  // Called one time unit after a rising edge with the unit idle.
  task automatic run_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] exp_res, input int exp_lat, input bit release_res);
    int lat;
    chk("in_ready_before", in_ready, 1);
    op = o;
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("res", res, exp_res);
`ifdef NLU_PARITY_EN
    chk("res_par", res_par, ^exp_res);
`endif
    if (release_res) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("in_ready_after", in_ready, 1);
      chk("out_valid_after", out_valid, 0);
    end
  endtask

  logic [7:0] sweep_res [8] = '{8'h3F, 8'hC0, 8'hFC, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
  int         sweep_lat [8] = '{1, 2, 3, 4, 4, 5, 1, 2};

  initial begin
    #3;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res", res, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    run_op(3'd2, 8'hA5, 8'h0F, 8'hAF, 3, 1'b1);
    run_op(3'd4, 8'hFF, 8'h0F, 8'hF0, 4, 1'b1);
    run_op(3'd5, 8'hFF, 8'h0F, 8'h0F, 5, 1'b1);
    for (int i = 0; i < 8; i++) begin
      run_op(3'(i), 8'hF0, 8'hCC, sweep_res[i], sweep_lat[i], 1'b1);
    end

    // Backpressure: result held, new operands ignored while DONE.
    run_op(3'd0, 8'hF0, 8'hCC, 8'h3F, 1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      a = 8'h00;
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_res", res, 8'h3F);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_out_valid", out_valid, 0);
    run_op(3'd6, 8'h55, 8'h00, 8'hAA, 1, 1'b1);

    // Reset while XOR sits at step 2.
    op = 3'd4;
    a = 8'hFF;
    b = 8'h0F;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_res", res, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(3'd1, 8'h0F, 8'h3C, 8'h0C, 2, 1'b1);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
